rx_sequence_chip_reader: RTL and testbench

Receive-side stage directly downstream of the 16-sequence binary-sequence BRAM (256 × 16, one sequence per bit column, 255 chips per sequence). On a start request it drives the BRAM read port through rows 0..254. It extracts the bit column of the selected sequence and presents the chips in order as a valid/ready stream to the correlator. A 4-entry credit-based buffer absorbs the BRAM's 1-cycle registered read latency, so backpressure never loses or duplicates a chip.

---
 rtl/rx_sequence_chip_reader.sv | 108 ++++++++++
 tb/tb_rx_sequence_chip_reader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rx_sequence_chip_reader.sv
// Reads one bit column of the sequence BRAM over rows 0..SEQ_LEN-1 and streams it as chips.
// A 4-entry credit-managed FIFO hides the 1-cycle BRAM read latency under backpressure.
module rx_sequence_chip_reader #(
  parameter int SEQ_LEN = 255,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        seq_sel,
  output logic              bram_enb,
  output logic [ADDR_W-1:0] bram_addrb,
  input  logic [DATA_W-1:0] bram_dob,
  output logic              chip_valid,
  input  logic              chip_ready,
  output logic              chip,
  output logic [ADDR_W-1:0] chip_index,
  output logic              chip_last,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start; read counter held at 0
  // RUN   | issuing reads and streaming chips
  // DONE  | one-cycle done pulse, then back to IDLE
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W:0]   LEN_C    = (ADDR_W+1)'(SEQ_LEN);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SEQ_LEN - 1);
  localparam logic [3:0]        TOP_BIT  = 4'(DATA_W - 1);

  logic [1:0]        state_q;
  logic [3:0]        sel_q;
  logic [ADDR_W:0]   rd_addr;
  logic              inflight_q;
  logic [ADDR_W-1:0] inflight_idx_q;
  logic [2:0]        count_q;
  logic [1:0]        wr_ptr_q;
  logic [1:0]        rd_ptr_q;
  logic              fifo_bit [4];
  logic [ADDR_W-1:0] fifo_idx [4];

  logic       issue;
  logic       push;
  logic       pop;
  logic [3:0] bit_pos;

  // Credit counts the in-flight read so the FIFO can never be overrun.
  assign issue   = (state_q == S_RUN) && (rd_addr < LEN_C) &&
                   ((count_q + 3'(inflight_q)) < 3'd4);
  assign push    = inflight_q;
  assign pop     = chip_valid && chip_ready;
  assign bit_pos = TOP_BIT - sel_q;

  assign bram_enb   = issue;
  assign bram_addrb = issue ? rd_addr[ADDR_W-1:0] : '0;
  assign chip_valid = (count_q != 3'd0);
  assign chip       = chip_valid && fifo_bit[rd_ptr_q];
  assign chip_index = chip_valid ? fifo_idx[rd_ptr_q] : '0;
  assign chip_last  = chip_valid && (fifo_idx[rd_ptr_q] == LAST_IDX);
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state_q        <= S_IDLE;
      sel_q          <= '0;
      rd_addr        <= '0;
      inflight_q     <= 1'b0;
      inflight_idx_q <= '0;
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
    end else begin
      inflight_q     <= issue;
      inflight_idx_q <= rd_addr[ADDR_W-1:0];
      if (issue) rd_addr <= rd_addr + 1'b1;

      if (push) begin
        fifo_bit[wr_ptr_q] <= bram_dob[bit_pos];
        fifo_idx[wr_ptr_q] <= inflight_idx_q;
        wr_ptr_q           <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      if (push && !pop)      count_q <= count_q + 3'd1;
      else if (!push && pop) count_q <= count_q - 3'd1;

      case (state_q)
        S_IDLE: begin
          rd_addr <= '0;
          if (start) begin
            sel_q   <= seq_sel;
            state_q <= S_RUN;
          end
        end
        S_RUN:   if (pop && chip_last) state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_sequence_chip_reader.sv
// Randomized bench: BRAM model plus a column-extraction reference and per-chip scoreboard.
module tb_rx_sequence_chip_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  seq_sel = '0;
  logic        bram_enb;
  logic [7:0]  bram_addrb;
  logic [15:0] bram_dob = '0;
  logic        chip_valid;
  logic        chip_ready = 1'b0;
  logic        chip;
  logic [7:0]  chip_index;
  logic        chip_last;
  logic        busy;
  logic        done;

  logic [15:0] mem [256];
  int n_cmp = 0;
  int n_err = 0;

  rx_sequence_chip_reader #(.SEQ_LEN(255), .ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seq_sel(seq_sel),
    .bram_enb(bram_enb), .bram_addrb(bram_addrb), .bram_dob(bram_dob),
    .chip_valid(chip_valid), .chip_ready(chip_ready), .chip(chip),
    .chip_index(chip_index), .chip_last(chip_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bram_enb) bram_dob <= mem[bram_addrb];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: sequence s is bit column (15 - s) of row i.
  function automatic logic model_chip(input int idx, input logic [3:0] sel);
    logic [15:0] row;
    row = mem[idx];
    return row[15 - int'(sel)];
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_enb"},   32'(bram_enb),   0);
    check({tag, "_addr"},  32'(bram_addrb), 0);
    check({tag, "_valid"}, 32'(chip_valid), 0);
    check({tag, "_chip"},  32'(chip),       0);
    check({tag, "_idx"},   32'(chip_index), 0);
    check({tag, "_last"},  32'(chip_last),  0);
    check({tag, "_busy"},  32'(busy),       0);
    check({tag, "_done"},  32'(done),       0);
  endtask

  // mode 0: ready high; 1: ready low in cycles 3..20; 2: random ready.
  // kill_cyc >= 0 asserts abort (or rst) in that cycle and ends the run the next cycle.
  task automatic run_seq(input logic [3:0] sel, input int mode, input int restart_cyc,
                         input int kill_cyc, input bit kill_rst);
    int   exp_idx = 0;
    int   enb_cnt = 0;
    bit   fin = 0;
    logic prev_stall = 0;
    logic prev_chip = 0;
    logic [7:0] prev_idx = '0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      start   = (c == 0) || (c == restart_cyc);
      seq_sel = (c == 0) ? sel : 4'($urandom);
      case (mode)
        0:       chip_ready = 1'b1;
        1:       chip_ready = !(c >= 3 && c <= 20);
        default: chip_ready = 1'($urandom_range(0, 1));
      endcase
      abort = !kill_rst && (c == kill_cyc);
      rst   = kill_rst && (c == kill_cyc);
      #1;
      if (kill_cyc >= 0 && c == kill_cyc + 1) begin
        check_zero(kill_rst ? "after_rst" : "after_abort");
        fin = 1;
      end else begin
        if (bram_enb) enb_cnt++;
        if (prev_stall) begin
          check("hold_valid", 32'(chip_valid), 1);
          check("hold_chip",  32'(chip),       32'(prev_chip));
          check("hold_idx",   32'(chip_index), 32'(prev_idx));
        end
        if (c == 1) begin
          check("c1_busy", 32'(busy),       1);
          check("c1_enb",  32'(bram_enb),   1);
          check("c1_addr", 32'(bram_addrb), 0);
        end
        if (c == 2) check("c2_valid", 32'(chip_valid), 0);
        if (c == 3) begin
          check("c3_valid", 32'(chip_valid), 1);
          check("c3_idx",   32'(chip_index), 0);
        end
        if (mode == 0 && c == 256) check("c256_last", 32'(chip_last), 0);
        if (mode == 0 && c == 257) check("c257_last", 32'(chip_last), 1);
        if (mode == 1 && c == 20)  check("stall_enb_le4", 32'(enb_cnt <= 4), 1);
        if (chip_valid && chip_ready) begin
          check("idx",  32'(chip_index), 32'(exp_idx));
          check("chip", 32'(chip), 32'(model_chip(exp_idx, sel)));
          check("last", 32'(chip_last), 32'(exp_idx == 254));
          if (mode == 0) check("no_bubble", 32'(c), 32'(exp_idx + 3));
          exp_idx++;
        end
        prev_stall = chip_valid && !chip_ready;
        prev_chip  = chip;
        prev_idx   = chip_index;
        if (done) begin
          check("done_count", 32'(exp_idx), 255);
          check("done_busy",  32'(busy), 0);
          check("done_unexp", 32'(kill_cyc < 0), 1);
          if (mode == 0) check("done_cycle", 32'(c), 258);
          fin = 1;
        end
      end
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    if (!fin) check("timeout", 0, 1);
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 16'($urandom);
    mem[0] = 16'h626B;
    mem[1] = 16'h8ECA;
    mem[2] = 16'h8765;
    mem[3] = 16'h3C4D;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_zero("idle");

    run_seq(4'd0,  0, -1, -1, 0);
    run_seq(4'd15, 0, -1, -1, 0);
    run_seq(4'd1,  0, -1, -1, 0);
    run_seq(4'd0,  1, -1, -1, 0);
    run_seq(4'd6,  2, -1, -1, 0);
    run_seq(4'd9,  0, 100, -1, 0);
    run_seq(4'd3,  0, -1, 50, 0);
    run_seq(4'd0,  0, -1, -1, 0);
    run_seq(4'd11, 2, -1, -1, 0);
    run_seq(4'd2,  0, -1, 50, 1);
    run_seq(4'd12, 0, -1, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
